// File: rtl/tdm_pkg.sv
// -----------------------------------------------------------------------------
// tdm_pkg -- shared definitions for the TDM receive demultiplexer.
//
// Contents:
//   NCH_DEF, W_DEF : default channel count and bits per channel slot
//   tdm_state_t    : receiver FSM state encoding (HUNT, RECV, PAR)
//
// PAR is only reachable when the design is built with TDM_PARITY_EN defined.
// -----------------------------------------------------------------------------
package tdm_pkg;

    localparam int unsigned NCH_DEF = 4;
    localparam int unsigned W_DEF   = 2;

    typedef enum logic [1:0] {
        HUNT = 2'd0,   // waiting for fsync
        RECV = 2'd1,   // collecting frame data bits
        PAR  = 2'd2    // expecting the trailing even-parity bit
    } tdm_state_t;

endpackage : tdm_pkg

// File: rtl/tdm_slot_ctr.sv
// -----------------------------------------------------------------------------
// tdm_slot_ctr -- frame bit counter for the TDM receiver.
//
// The count holds the index of the next frame bit to be sampled. It is
// cleared, loaded with 1 (a frame bit 0 was just taken) or incremented.
// Increment saturates at all-ones so the count can never wrap.
//
// Parameters:
//   CW   : counter width
//   LAST : count value that flags the final data bit of a frame
//
// Ports:
//   clk   in  rising-edge clock
//   rst_n in  asynchronous active-low reset (count -> 0)
//   clr   in  clear count to 0 (highest priority)
//   ld1   in  load count with 1
//   inc   in  increment count
//   tc    out terminal count: the bit being sampled now is the last data bit
// -----------------------------------------------------------------------------
module tdm_slot_ctr #(
    parameter int unsigned CW   = 4,
    parameter int unsigned LAST = 7
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic ld1,
    input  logic inc,
    output logic tc
);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (ld1) begin
            cnt <= CW'(1);
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + CW'(1);
        end
    end

    assign tc = (cnt == CW'(LAST));

endmodule : tdm_slot_ctr

// File: rtl/tdm_demux.sv
// -----------------------------------------------------------------------------
// tdm_demux -- receive end of a serial TDM link.
//
// One sin bit is sampled per clock. fsync marks frame bit 0. A frame carries
// NCH channels of W bits each, channel 0 first, each channel MSB first.
// A complete frame is demultiplexed into ch_data with channel k at
// ch_data[k*W +: W]. ch_data only changes together with a frame_valid pulse.
//
// Build option:
//   TDM_PARITY_EN : when defined, each frame carries one trailing even-parity
//                   bit after the last data bit and the parity_err output
//                   exists. A frame with bad parity is dropped.
//
// Parameters:
//   NCH : channels per frame
//   W   : bits per channel slot
//
// Ports:
//   clk         in  rising-edge clock
//   rst_n       in  asynchronous active-low reset
//   sin         in  serial data
//   fsync       in  high in the cycle whose sin bit is frame bit 0
//   ch_data     out last good frame, NCH*W bits
//   frame_valid out one-cycle pulse when ch_data is updated
//   sync_err    out one-cycle pulse on a premature fsync
//   parity_err  out one-cycle pulse on a parity failure (TDM_PARITY_EN only)
// -----------------------------------------------------------------------------
module tdm_demux
    import tdm_pkg::*;
#(
    parameter int unsigned NCH = NCH_DEF,
    parameter int unsigned W   = W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sin,
    input  logic             fsync,
    output logic [NCH*W-1:0] ch_data,
    output logic             frame_valid,
    output logic             sync_err
`ifdef TDM_PARITY_EN
    ,
    output logic             parity_err
`endif
);

    localparam int unsigned F  = NCH * W;
    localparam int unsigned CW = $clog2(F + 2);

`ifdef TDM_PARITY_EN
    localparam int unsigned PAR_BITS = 1;
`else
    localparam int unsigned PAR_BITS = 0;
`endif

    // Without parity the final data bit is taken straight from sin when the
    // frame is loaded, so the shift register only needs to hold F-1 bits.
    localparam int unsigned SR_W = F - 1 + PAR_BITS;

    tdm_state_t      state;
    logic [SR_W-1:0] sr;
    logic [SR_W:0]   shifted;
    logic [F-1:0]    frame;
    logic [F-1:0]    mapped;
    logic            last_bit;
    logic            ctr_clr;
    logic            ctr_ld1;
    logic            ctr_inc;
`ifdef TDM_PARITY_EN
    logic            par_ok;
`endif

    // ------------------------------------------------------------------
    // Bit counter
    // ------------------------------------------------------------------
    tdm_slot_ctr #(
        .CW   (CW),
        .LAST (F - 1)
    ) u_slot_ctr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (ctr_clr),
        .ld1   (ctr_ld1),
        .inc   (ctr_inc),
        .tc    (last_bit)
    );

    always_comb begin
        ctr_clr = 1'b0;
        ctr_ld1 = 1'b0;
        ctr_inc = 1'b0;
        case (state)
            HUNT: begin
                ctr_ld1 = fsync;
            end
            RECV: begin
                if (fsync && !last_bit) begin
                    ctr_ld1 = 1'b1;
                end else if (last_bit) begin
`ifdef TDM_PARITY_EN
                    ctr_inc = 1'b1;
`else
                    ctr_clr = 1'b1;
`endif
                end else begin
                    ctr_inc = 1'b1;
                end
            end
`ifdef TDM_PARITY_EN
            PAR: begin
                if (fsync) begin
                    ctr_ld1 = 1'b1;
                end else begin
                    ctr_clr = 1'b1;
                end
            end
`endif
            default: begin
                ctr_clr = 1'b1;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Frame assembly and channel mapping
    // ------------------------------------------------------------------
    // Frame bit 0 ends up in the MSB of the assembled frame, so channel 0
    // occupies the top W bits; channels are reversed into ch_data order.
    always_comb begin
        shifted = {sr, sin};
`ifdef TDM_PARITY_EN
        frame   = sr;
        par_ok  = ~(^shifted);
`else
        frame   = shifted;
`endif
        mapped  = '0;
        for (int unsigned k = 0; k < NCH; k++) begin
            mapped[k*W +: W] = frame[(NCH-1-k)*W +: W];
        end
    end

    // ------------------------------------------------------------------
    // Receiver FSM with registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= HUNT;
            sr          <= '0;
            ch_data     <= '0;
            frame_valid <= 1'b0;
            sync_err    <= 1'b0;
`ifdef TDM_PARITY_EN
            parity_err  <= 1'b0;
`endif
        end else begin
            frame_valid <= 1'b0;
            sync_err    <= 1'b0;
`ifdef TDM_PARITY_EN
            parity_err  <= 1'b0;
`endif
            case (state)
                HUNT: begin
                    if (fsync) begin
                        sr    <= SR_W'(sin);
                        state <= RECV;
                    end
                end

                RECV: begin
                    if (fsync && !last_bit) begin
                        // Premature fsync: drop the partial frame and restart.
                        sync_err <= 1'b1;
                        sr       <= SR_W'(sin);
                    end else begin
                        sr <= shifted[SR_W-1:0];
                        if (last_bit) begin
`ifdef TDM_PARITY_EN
                            state <= PAR;
`else
                            ch_data     <= mapped;
                            frame_valid <= 1'b1;
                            state       <= HUNT;
`endif
                        end
                    end
                end

`ifdef TDM_PARITY_EN
                PAR: begin
                    if (fsync) begin
                        sync_err <= 1'b1;
                        sr       <= SR_W'(sin);
                        state    <= RECV;
                    end else begin
                        if (par_ok) begin
                            ch_data     <= mapped;
                            frame_valid <= 1'b1;
                        end else begin
                            parity_err  <= 1'b1;
                        end
                        state <= HUNT;
                    end
                end
`endif

                default: begin
                    state <= HUNT;
                end
            endcase
        end
    end

endmodule : tdm_demux
